// File: rtl/piezo_tone_player.sv
// piezo_tone_player: queued note player driving a piezo differentially from a DEPTH-entry note FIFO
// Ports: CLK_IN/RST_IN clock and sync active-high reset; NOTE_VALID_IN/NOTE_READY_OUT push handshake
// carrying NOTE_DIV_IN (tone period in clocks, <2 = rest) and NOTE_DUR_IN (ticks, 0 = skip);
// PIEZO_P_OUT/PIEZO_N_OUT differential drive; BUSY_OUT queue or player active; LED_OUT mirrors PIEZO_P_OUT.
// Optional macro PIEZO_TONE_GAP_EN silences the final tick of notes lasting two or more ticks.
module piezo_tone_player #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int TICK_HZ = 1000,
  parameter int DIV_W = 24,
  parameter int DUR_W = 16,
  parameter int DEPTH = 4
) (
  input logic CLK_IN,
  input logic RST_IN,
  input logic NOTE_VALID_IN,
  output logic NOTE_READY_OUT,
  input logic [DIV_W-1:0] NOTE_DIV_IN,
  input logic [DUR_W-1:0] NOTE_DUR_IN,
  output logic PIEZO_P_OUT,
  output logic PIEZO_N_OUT,
  output logic BUSY_OUT,
  output logic LED_OUT
);
  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(DEPTH);
  localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] ONE_P = PW'(1);
  localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);
  localparam logic [DUR_W-1:0] ONE_U = DUR_W'(1);
  localparam logic [AW:0] ONE_C = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
  state_t state;
  logic [DIV_W-1:0] div_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_n;
  logic push, pop, ne_r, tone, last, wave_n, gap_n;
  logic [DIV_W-1:0] div_r, phase, phase_n, half, head_div;
  logic [DUR_W-1:0] dur_r, dur_n, head_dur;
  logic [PW-1:0] pre;
  assign push = NOTE_VALID_IN && NOTE_READY_OUT;
  assign pop = state == LOAD;
  assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);
  assign head_div = div_mem[rd_ptr];
  assign head_dur = dur_mem[rd_ptr];
  assign tone = div_r > ONE_D;
  assign half = div_r >> 1;
  assign phase_n = phase == '0 ? (tone ? div_r - ONE_D : '0) : phase - ONE_D;
  assign dur_n = pre == '0 ? dur_r - ONE_U : dur_r;
  assign last = pre == '0 && dur_r == ONE_U;
  assign wave_n = tone && phase_n >= half;
  assign LED_OUT = PIEZO_P_OUT;
`ifdef PIEZO_TONE_GAP_EN
  logic gap_ok;
  assign gap_n = gap_ok && dur_n == ONE_U;
`else
  assign gap_n = 1'b0;
`endif
  always_ff @(posedge CLK_IN) begin
    if (push) begin
      div_mem[wr_ptr] <= NOTE_DIV_IN;
      dur_mem[wr_ptr] <= NOTE_DUR_IN;
    end
  end
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ne_r <= 1'b0;
      NOTE_READY_OUT <= 1'b0;
      BUSY_OUT <= 1'b0;
      PIEZO_P_OUT <= 1'b0;
      PIEZO_N_OUT <= 1'b0;
      div_r <= '0;
      dur_r <= '0;
      phase <= '0;
      pre <= '0;
`ifdef PIEZO_TONE_GAP_EN
      gap_ok <= 1'b0;
`endif
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count_n;
      // one-cycle delayed occupancy gives the IDLE stage its settling cycle before LOAD
      ne_r <= count != '0;
      NOTE_READY_OUT <= count_n != FULL;
      BUSY_OUT <= count_n != '0;
      PIEZO_P_OUT <= 1'b0;
      PIEZO_N_OUT <= 1'b0;
      case (state)
        IDLE: if (ne_r && count != '0) begin
          state <= LOAD;
          BUSY_OUT <= 1'b1;
        end
        LOAD: begin
          div_r <= head_div;
          dur_r <= head_dur;
          phase <= head_div > ONE_D ? head_div - ONE_D : '0;
          pre <= PRE_TOP;
`ifdef PIEZO_TONE_GAP_EN
          gap_ok <= head_dur > ONE_U;
`endif
          // the first phase value div-1 always lies in the high half of the wave
          PIEZO_P_OUT <= head_dur != '0 && head_div > ONE_D;
          state <= head_dur != '0 ? PLAY : count > ONE_C ? LOAD : IDLE;
          BUSY_OUT <= head_dur != '0 || count > ONE_C || count_n != '0;
        end
        PLAY: begin
          phase <= phase_n;
          pre <= pre == '0 ? PRE_TOP : pre - ONE_P;
          dur_r <= dur_n;
          PIEZO_P_OUT <= !last && !gap_n && wave_n;
          PIEZO_N_OUT <= !last && !gap_n && tone && !wave_n;
          state <= !last ? PLAY : count != '0 ? LOAD : IDLE;
          BUSY_OUT <= !last || count_n != '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piezo_tone_player.sv
// tb_piezo_tone_player: directed self-checking bench for piezo_tone_player with TICK_DIV=10
module tb_piezo_tone_player;
  logic clk = 1'b0;
  logic rst, valid, ready, p, n, busy, led;
  logic [23:0] div;
  logic [15:0] dur;
  int errors = 0;
  int checks = 0;
  int waits;
`ifdef PIEZO_TONE_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif
  piezo_tone_player #(.CLK_FREQ(1000), .TICK_HZ(100), .DIV_W(24), .DUR_W(16), .DEPTH(4)) dut (
    .CLK_IN(clk), .RST_IN(rst), .NOTE_VALID_IN(valid), .NOTE_READY_OUT(ready),
    .NOTE_DIV_IN(div), .NOTE_DUR_IN(dur), .PIEZO_P_OUT(p), .PIEZO_N_OUT(n),
    .BUSY_OUT(busy), .LED_OUT(led)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push(input int d, input int u, output int w);
    w = 0;
    valid = 1'b1;
    div = 24'(d);
    dur = 16'(u);
    while (!ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("push_ready", 32'(ready), 32'd1);
    @(negedge clk);
    valid = 1'b0;
  endtask
  task automatic play(input int d, input int u);
    for (int k = 0; k < u * 10; k++) begin
      bit w, g;
      @(negedge clk);
      w = d >= 2 ? (k % d) < (d + 1) / 2 : 1'b0;
      g = GAP && u >= 2 && k >= (u - 1) * 10;
      chk("play_p", 32'(p), 32'(w && !g));
      chk("play_n", 32'(n), 32'(d >= 2 && !w && !g));
      chk("play_led", 32'(led), 32'(w && !g));
    end
  endtask
  initial begin
    rst = 1'b1;
    valid = 1'b0;
    div = '0;
    dur = '0;
    repeat (3) @(negedge clk);
    chk("rst_p", 32'(p), 0);
    chk("rst_n", 32'(n), 0);
    chk("rst_led", 32'(led), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_rise", 32'(ready), 1);
    push(4, 2, waits);
    chk("t1_busy_push", 32'(busy), 1);
    repeat (2) @(negedge clk);
    chk("t1_load_p", 32'(p), 0);
    chk("t1_load_n", 32'(n), 0);
    play(4, 2);
    @(negedge clk);
    chk("t1_idle_p", 32'(p), 0);
    chk("t1_idle_busy", 32'(busy), 0);
    push(5, 1, waits);
    repeat (2) @(negedge clk);
    chk("t2_load_p", 32'(p), 0);
    play(5, 1);
    @(negedge clk);
    chk("t2_idle_p", 32'(p), 0);
    push(0, 3, waits);
    repeat (2) @(negedge clk);
    push(4, 1, waits);
    push(5, 1, waits);
    push(2, 1, waits);
    push(6, 1, waits);
    chk("t3_full_ready", 32'(ready), 0);
    chk("t3_rest_p", 32'(p), 0);
    fork
      begin
        int w5;
        push(3, 1, w5);
        chk("t3_stall_cycles", 32'(w5), 28);
      end
      begin
        repeat (27) @(negedge clk);
        chk("t3_load_b", 32'(p), 0);
        play(4, 1);
        @(negedge clk);
        chk("t3_load_c", 32'(p), 0);
        play(5, 1);
        @(negedge clk);
        chk("t3_load_d", 32'(p), 0);
        play(2, 1);
        @(negedge clk);
        chk("t3_load_e", 32'(p), 0);
        play(6, 1);
        @(negedge clk);
        chk("t3_load_f", 32'(p), 0);
        play(3, 1);
        @(negedge clk);
        chk("t3_idle_p", 32'(p), 0);
        chk("t3_idle_busy", 32'(busy), 0);
      end
    join
    push(0, 3, waits);
    push(6, 0, waits);
    push(2, 1, waits);
    chk("t4_load_p", 32'(p), 0);
    play(0, 3);
    @(negedge clk);
    chk("t4_load2_p", 32'(p), 0);
    @(negedge clk);
    chk("t4_skip_p", 32'(p), 0);
    chk("t4_skip_n", 32'(n), 0);
    play(2, 1);
    @(negedge clk);
    chk("t4_idle_p", 32'(p), 0);
    push(8, 3, waits);
    push(4, 1, waits);
    push(4, 1, waits);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_p", 32'(p), 0);
    chk("t5_rst_n", 32'(n), 0);
    chk("t5_rst_led", 32'(led), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_ready", 32'(ready), 0);
    @(negedge clk);
    chk("t5_ready_back", 32'(ready), 1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("t5_silent_p", 32'(p), 0);
      chk("t5_silent_busy", 32'(busy), 0);
    end
`ifdef PIEZO_TONE_GAP_EN
    push(4, 3, waits);
    repeat (2) @(negedge clk);
    chk("gap_load_p", 32'(p), 0);
    play(4, 3);
    @(negedge clk);
    chk("gap_idle_p", 32'(p), 0);
    chk("gap_idle_busy", 32'(busy), 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
